// File: rtl/bgr_startup_seq_if.sv
// Bandgap start-up sequencer signal bundle: start request, bandgap level, sequencer status.
// Latency: none (wires only).
// Backpressure: none; every signal is a level.
`timescale 1ns/1ps
interface bgr_startup_seq_if;
    logic       en;
    logic       vbg_i;
    logic       porst;
    logic       ref_ready;
    logic       fault;
    logic [2:0] state_o;

    // Controller side: requests start-up and supplies the bandgap level.
    modport master (
        output en, vbg_i,
        input  porst, ref_ready, fault, state_o
    );

    // Sequencer side.
    modport slave (
        input  en, vbg_i,
        output porst, ref_ready, fault, state_o
    );
endinterface

// File: rtl/bgr_startup_seq.sv
// Bandgap start-up sequencer: porst pulse, wait for vbg, qualify vbg over a settle window, flag faults.
// Latency: vbg_i to state reaction 2 clocks (synchronizer); all outputs registered.
// Backpressure: none; en low aborts to IDLE from any state and clears a latched fault.
`timescale 1ns/1ps
module bgr_startup_seq #(
    parameter int PORST_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    bgr_startup_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PORST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             sync1_q, sync2_q;
    logic             vbg_s;
    logic             porst_q, ready_q, fault_q;

    // Counters stick at full scale instead of wrapping back into a match window.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchronizer for the asynchronous bandgap level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.vbg_i;
            sync2_q <= sync1_q;
        end
    end

    assign vbg_s = sync2_q;

    // Next-state and counter rules; en low outranks everything outside IDLE.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        if (state_q != ST_IDLE && !bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pcnt_d = '0;
                    tcnt_d = '0;
                    if (bus.en) state_d = ST_PULSE;
                end
                ST_PULSE: begin
                    if (pcnt_q == PULSE_LAST) begin
                        state_d = ST_WAIT;
                        tcnt_d  = '0;
                    end else begin
                        pcnt_d = sat_inc(pcnt_q);
                    end
                end
                ST_WAIT: begin
                    tcnt_d = sat_inc(tcnt_q);
                    if (vbg_s) begin
                        state_d = ST_SETTLE;
                        pcnt_d  = '0;
                    end else if (tcnt_q == TIMEOUT_LAST) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_SETTLE: begin
                    tcnt_d = sat_inc(tcnt_q);
                    // A low sample restarts the window; completing the window beats a same-cycle timeout.
                    if (!vbg_s) begin
                        pcnt_d = '0;
                    end else if (pcnt_q == SETTLE_LAST) begin
                        state_d = ST_READY;
                    end else if (tcnt_q == TIMEOUT_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        pcnt_d = sat_inc(pcnt_q);
                    end
                end
                ST_READY: begin
                    if (!vbg_s) state_d = ST_FAULT;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and outputs registered together so outputs never glitch.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            porst_q <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            porst_q <= (state_d == ST_PULSE);
            ready_q <= (state_d == ST_READY);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign bus.porst     = porst_q;
    assign bus.ref_ready = ready_q;
    assign bus.fault     = fault_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_bgr_startup_seq.sv
// Bench for bgr_startup_seq: directed scenarios plus random vbg waveforms scored by an event-time model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_bgr_startup_seq;

    localparam int PULSE = 16;
    localparam int SETTLE = 64;
    localparam int TMO = 1024;
    localparam int W_ENTRY = PULSE + 1;            // first edge that observes WAIT
    localparam int T_LAST = W_ENTRY + TMO - 1;     // edge at which the timeout decision is made
    localparam int NMAX = 1200;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    bit         vin [0:NMAX-1];   // vbg_i value seen by edge k of a trial
    logic [5:0] obs [0:NMAX-1];   // {state_o, porst, ref_ready, fault} seen by edge k

    bgr_startup_seq_if bus ();

    bgr_startup_seq dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] cur();
        return {bus.state_o, bus.porst, bus.ref_ready, bus.fault};
    endfunction

    function automatic logic [5:0] code_of(input int s);
        logic [2:0] s3;
        s3 = s[2:0];
        return {s3, (s == 1), (s == 4), (s == 5)};
    endfunction

    // Synchronized bandgap level as it reaches the sequencer at edge e.
    function automatic bit vs(input int e);
        return (e >= 2) ? vin[e-2] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_dut();
        bus.en    = 1'b0;
        bus.vbg_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Apply vin with en held high from edge 0; record what each edge sees.
    task automatic run_trial(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs[k]    = cur();
            bus.vbg_i = vin[k];
            bus.en    = 1'b1;
        end
    endtask

    // Event-time model: find WAIT exit, settle completion, timeout and loss edges, then score every edge.
    task automatic check_trial(input int n, input string tag);
        int t, r, f, run, s;
        t = -1; r = -1; f = -1;
        for (int e = W_ENTRY; e <= T_LAST; e++) begin
            if (vs(e)) begin t = e; break; end
        end
        if (t < 0) begin
            f = T_LAST;
        end else begin
            run = 0;
            for (int e = t + 1; e < NMAX; e++) begin
                run = vs(e) ? run + 1 : 0;
                if (run == SETTLE) begin r = e; break; end
            end
            if (t < T_LAST && (r < 0 || r > T_LAST) && vs(T_LAST)) begin
                r = -1;
                f = T_LAST;
            end
            if (r >= 0) begin
                for (int e = r + 1; e < NMAX; e++) begin
                    if (!vs(e)) begin f = e; break; end
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            if (k == 0)                  s = 0;
            else if (k <= PULSE)         s = 1;
            else if (f >= 0 && k > f)    s = 5;
            else if (t < 0 || k <= t)    s = 2;
            else if (r < 0 || k <= r)    s = 3;
            else                         s = 4;
            chk($sformatf("%s@%0d", tag, k), 32'(obs[k]), 32'(code_of(s)));
        end
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.vbg_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(cur()), 32'(code_of(0)));
        rst = 1'b0;
        idle_dut();
        chk("idle_after_reset", 32'(cur()), 32'(code_of(0)));

        // Nominal: vbg rises just after 500 ns past the porst rising edge.
        for (int k = 0; k < NMAX; k++) vin[k] = (k >= 51);
        run_trial(130);
        check_trial(130, "nominal");
        cnt = 0;
        for (int k = 0; k < 130; k++) cnt += int'(obs[k][2]);
        chk("nominal_porst_width", 32'(cnt), 32'(PULSE));
        chk("nominal_ready_118", 32'(obs[118][1]), 32'd1);
        chk("nominal_notready_117", 32'(obs[117][1]), 32'd0);
        idle_dut();

        // Timeout: vbg never rises.
        for (int k = 0; k < NMAX; k++) vin[k] = 1'b0;
        run_trial(1045);
        check_trial(1045, "timeout");
        chk("timeout_wait_17", 32'(obs[17][5:3]), 32'd2);
        chk("timeout_fault_1041", 32'(obs[1041]), 32'(code_of(5)));
        chk("timeout_nofault_1040", 32'(obs[1040][0]), 32'd0);
        idle_dut();

        // Settle glitch: three low clocks about 30 clocks into SETTLE.
        for (int k = 0; k < NMAX; k++) vin[k] = (k >= 20) && !(k >= 50 && k <= 52);
        run_trial(140);
        check_trial(140, "glitch");
        chk("glitch_ready_119", 32'(obs[119]), 32'(code_of(4)));
        chk("glitch_settle_118", 32'(obs[118]), 32'(code_of(3)));
        idle_dut();

        // Loss in READY at edge 150, then en drop clears the fault.
        for (int k = 0; k < NMAX; k++) vin[k] = (k >= 20) && (k < 150);
        run_trial(160);
        check_trial(160, "loss");
        chk("loss_ready_152", 32'(obs[152]), 32'(code_of(4)));
        chk("loss_fault_153", 32'(obs[153]), 32'(code_of(5)));
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk("loss_en_drop_idle", 32'(cur()), 32'(code_of(0)));
        idle_dut();

        // Settle completion on the very edge the timeout expires: READY wins.
        for (int k = 0; k < NMAX; k++) vin[k] = (k >= 974);
        run_trial(1050);
        check_trial(1050, "ready_vs_timeout");
        chk("rvt_ready_1041", 32'(obs[1041]), 32'(code_of(4)));
        idle_dut();

        // vbg keeps toggling with 40-clock runs: settle window never completes.
        for (int k = 0; k < NMAX; k++) vin[k] = (((k + 10) / 40) % 2) == 0;
        run_trial(1050);
        check_trial(1050, "settle_timeout");
        chk("st_fault_1041", 32'(obs[1041]), 32'(code_of(5)));
        idle_dut();

        // Random vbg waveforms: random rise, optional glitch, optional loss.
        for (int trial = 0; trial < 6; trial++) begin
            int rise, gs, gl, loss;
            rise = int'($urandom_range(3, 120));
            gs   = rise + int'($urandom_range(5, 90));
            gl   = int'($urandom_range(0, 4));
            loss = ($urandom_range(0, 1) == 1) ? int'($urandom_range(300, 350)) : NMAX;
            for (int k = 0; k < NMAX; k++)
                vin[k] = (k >= rise) && !(k >= gs && k < gs + gl) && (k < loss);
            run_trial(360);
            check_trial(360, $sformatf("rand%0d", trial));
            idle_dut();
        end

        // Abort during PULSE, then restart gives a full pulse.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.vbg_i = 1'b0;
            bus.en    = (k < 5);
        end
        @(negedge clk);
        chk("abort_idle_6", 32'(cur()), 32'(code_of(0)));
        bus.en = 1'b1;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            cnt += int'(bus.porst);
        end
        chk("restart_porst_width", 32'(cnt), 32'(PULSE));
        idle_dut();

        // Reset pulse in SETTLE with en held high.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.vbg_i = 1'b1;
            bus.en    = 1'b1;
        end
        @(negedge clk);
        chk("rst_mid_in_settle", 32'(cur()), 32'(code_of(3)));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs_zero", 32'(cur()), 32'(code_of(0)));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_restart_pulse", 32'(cur()), 32'(code_of(1)));
        idle_dut();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
